// File: rtl/axi_wr_fence_pkg.sv
// Shared types and constants for the AXI write-path isolation fence.
package axi_wr_fence_pkg;

    // Fence FSM states; StFAw/StFW/StFB together form the FENCE region.
    typedef enum logic [2:0] {
        StPass  = 3'd0,
        StDrain = 3'd1,
        StFAw   = 3'd2,
        StFW    = 3'd3,
        StFB    = 3'd4
    } fence_state_e;

    // Config register offsets
    localparam logic [11:0] REG_CTRL = 12'h000;
    localparam logic [11:0] REG_OUTS = 12'h004;
    localparam logic [11:0] REG_CNT  = 12'h008;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // True while the fence is terminating a write locally (W or B phase).
    function automatic logic in_local_burst(input fence_state_e st);
        return (st == StFW) || (st == StFB);
    endfunction

endpackage

// File: rtl/axi_wr_fence_regs.sv
// Config-bus register block for axi_wr_fence: strobe edge detect, registered ack/read data,
// re-arm request and the fenced-write counter.
// Optional feature macro: AXI_WR_FENCE_CNT_EN (defined -> fence_cnt register implemented).
module axi_wr_fence_regs
    import axi_wr_fence_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cfg_addr,
    input  logic        cfg_wr,
    input  logic        cfg_rd,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_ack,
    output logic [31:0] cfg_rdata,
    input  logic [2:0]  status,
    input  logic [31:0] outstanding,
    input  logic        fence_inc,
    output logic        rearm_req
);

    logic        wr_q;
    logic        rd_q;
    logic        wr_rise;
    logic        rd_rise;
    logic [31:0] cnt_val;
    logic [31:0] rd_val;
    logic        unused_wdata;

    assign wr_rise      = cfg_wr & ~wr_q;
    assign rd_rise      = cfg_rd & ~rd_q;
    assign rearm_req    = wr_rise & (cfg_addr == REG_CTRL) & cfg_wdata[0];
    assign unused_wdata = ^cfg_wdata[31:1];

    // Strobe history for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= cfg_wr;
            rd_q <= cfg_rd;
        end
    end

`ifdef AXI_WR_FENCE_CNT_EN
    logic [31:0] cnt_q;

    // Saturating fenced-write counter; a clear write wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wr_rise && (cfg_addr == REG_CNT)) begin
            cnt_q <= '0;
        end else if (fence_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_val = cnt_q;
`else
    logic unused_fence_inc;

    assign unused_fence_inc = fence_inc;
    assign cnt_val          = '0;
`endif

    // Read-data decode
    always_comb begin
        rd_val = '0;
        case (cfg_addr)
            REG_CTRL: rd_val = {29'b0, status};
            REG_OUTS: rd_val = outstanding;
            REG_CNT:  rd_val = cnt_val;
            default:  rd_val = '0;
        endcase
    end

    // Registered ack and read data; read data holds until the next read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ack   <= 1'b0;
            cfg_rdata <= '0;
        end else begin
            cfg_ack <= wr_rise | rd_rise;
            if (rd_rise) begin
                cfg_rdata <= rd_val;
            end
        end
    end

endmodule

// File: rtl/axi_wr_fence.sv
// AXI write-path isolation fence. Passes AW/W/B through until the write-last checker flags an
// error, then drains in-flight bursts and answers every later master write locally with SLVERR.
// Optional feature macro: AXI_WR_FENCE_CNT_EN (fence_cnt register, see axi_wr_fence_regs).
module axi_wr_fence
    import axi_wr_fence_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_OUTS   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [11:0]             cfg_addr,
    input  logic                    cfg_wr,
    input  logic                    cfg_rd,
    input  logic [31:0]             cfg_wdata,
    output logic                    cfg_ack,
    output logic [31:0]             cfg_rdata,
    input  logic                    wr_last_error,
    output logic                    fence_active,
    // From master
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [LEN_WIDTH-1:0]    s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    // To slave
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [LEN_WIDTH-1:0]    m_awlen,
    output logic [2:0]              m_awsize,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    localparam int unsigned      CNT_W      = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] MAX_OUTS_C = CNT_W'(MAX_OUTS);

    fence_state_e        state_q;
    fence_state_e        state_d;
    logic [CNT_W-1:0]    outs_q;
    logic [CNT_W-1:0]    outs_d;
    logic [ID_WIDTH-1:0] fence_id_q;
    logic                aw_room;
    logic                outs_nz;
    logic                m_aw_hs;
    logic                m_b_dec;
    logic                rearm_req;
    logic                fence_inc;

    assign aw_room      = (outs_q < MAX_OUTS_C);
    assign outs_nz      = (outs_q != '0);
    assign m_aw_hs      = m_awvalid & m_awready;
    // Guarded so a spurious B can never wrap the count below zero
    assign m_b_dec      = m_bvalid & m_bready & outs_nz;
    assign fence_active = (state_q != StPass);
    assign fence_inc    = (state_q == StFB) & s_bready;

    // Payloads are wired straight through; only the valids/readies are gated by state
    assign m_awid   = s_awid;
    assign m_awaddr = s_awaddr;
    assign m_awlen  = s_awlen;
    assign m_awsize = s_awsize;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
    assign m_wlast  = s_wlast;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StPass;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an AW handshake in StFAw takes precedence over a same-cycle re-arm
    always_comb begin
        state_d = state_q;
        case (state_q)
            StPass:  if (wr_last_error) state_d = StDrain;
            StDrain: if (!outs_nz) state_d = StFAw;
            StFAw: begin
                if (s_awvalid) begin
                    state_d = StFW;
                end else if (rearm_req && !wr_last_error) begin
                    state_d = StPass;
                end
            end
            StFW:    if (s_wvalid && s_wlast) state_d = StFB;
            StFB:    if (s_bready) state_d = StFAw;
            default: state_d = StPass;
        endcase
    end

    // Handshake gating per state
    always_comb begin
        s_awready = 1'b0;
        m_awvalid = 1'b0;
        s_wready  = 1'b0;
        m_wvalid  = 1'b0;
        s_bvalid  = 1'b0;
        m_bready  = 1'b0;
        s_bid     = m_bid;
        s_bresp   = m_bresp;
        case (state_q)
            StPass: begin
                s_awready = m_awready & aw_room;
                m_awvalid = s_awvalid & aw_room;
                s_wready  = m_wready;
                m_wvalid  = s_wvalid;
                s_bvalid  = m_bvalid;
                m_bready  = s_bready;
            end
            StDrain: begin
                s_wready = m_wready;
                m_wvalid = s_wvalid;
                s_bvalid = m_bvalid & outs_nz;
                m_bready = s_bready & outs_nz;
            end
            StFAw: s_awready = 1'b1;
            StFW:  s_wready  = 1'b1;
            StFB: begin
                s_bvalid = 1'b1;
                s_bid    = fence_id_q;
                s_bresp  = RESP_SLVERR;
            end
            default: ;
        endcase
    end

    // Outstanding-write count: +1 per forwarded AW, -1 per returned B
    always_comb begin
        outs_d = outs_q;
        case ({m_aw_hs, m_b_dec})
            2'b10:   outs_d = outs_q + CNT_W'(1);
            2'b01:   outs_d = outs_q - CNT_W'(1);
            default: outs_d = outs_q;
        endcase
    end

    // Outstanding counter and locally terminated write ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outs_q     <= '0;
            fence_id_q <= '0;
        end else begin
            outs_q <= outs_d;
            if ((state_q == StFAw) && s_awvalid) begin
                fence_id_q <= s_awid;
            end
        end
    end

    axi_wr_fence_regs u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_addr    (cfg_addr),
        .cfg_wr      (cfg_wr),
        .cfg_rd      (cfg_rd),
        .cfg_wdata   (cfg_wdata),
        .cfg_ack     (cfg_ack),
        .cfg_rdata   (cfg_rdata),
        .status      ({in_local_burst(state_q), fence_active, wr_last_error}),
        .outstanding (32'(outs_q)),
        .fence_inc   (fence_inc),
        .rearm_req   (rearm_req)
    );

endmodule

// File: tb/tb_axi_wr_fence.sv
// Self-checking bench for axi_wr_fence: per-cycle comparison against a behavioural model plus
// directed scenarios with literal expectations.
module tb_axi_wr_fence;

    localparam int MAX_O = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cfg_addr;
    logic        cfg_wr, cfg_rd;
    logic [31:0] cfg_wdata;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic        wr_last_error;
    logic        fence_active;
    logic [7:0]  s_awid, m_awid, s_bid, m_bid;
    logic [31:0] s_awaddr, m_awaddr;
    logic [7:0]  s_awlen, m_awlen;
    logic [2:0]  s_awsize, m_awsize;
    logic        s_awvalid, s_awready, m_awvalid, m_awready;
    logic [63:0] s_wdata, m_wdata;
    logic [7:0]  s_wstrb, m_wstrb;
    logic        s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0]  s_bresp, m_bresp;
    logic        s_bvalid, s_bready, m_bvalid, m_bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_wr_fence #(
        .ID_WIDTH(8), .ADDR_WIDTH(32), .LEN_WIDTH(8), .DATA_WIDTH(64), .MAX_OUTS(MAX_O)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
        .wr_last_error(wr_last_error), .fence_active(fence_active),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bid(s_bid),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bid(m_bid),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {MP, MD, MFA, MFW, MFB} ph_e;
    ph_e         ph = MP;
    int          outs = 0;
    int          cnt = 0;
    logic [7:0]  fid = 0;
    bit          mvalid = 0;
    bit          wr_prev = 0, rd_prev = 0;
    logic        e_ack = 0;
    logic [31:0] e_rdata = 0;
    bit e_saw_rdy, e_maw_v, e_sw_rdy, e_mw_v, e_sb_v, e_mb_rdy;
    logic [7:0]  e_bid;
    logic [1:0]  e_bresp;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h000: return {29'b0, (ph == MFW || ph == MFB), ph != MP, wr_last_error};
            12'h004: return 32'(outs);
            12'h008: return 32'(cnt);
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        bit room, wr_r, rd_r, maw_hs, mb_hs;
        ph_e nph;
        room = (outs < MAX_O);
        e_saw_rdy = 0; e_maw_v = 0; e_sw_rdy = 0; e_mw_v = 0; e_sb_v = 0; e_mb_rdy = 0;
        e_bid = m_bid; e_bresp = m_bresp;
        case (ph)
            MP: begin
                e_saw_rdy = m_awready && room; e_maw_v = s_awvalid && room;
                e_sw_rdy = m_wready; e_mw_v = s_wvalid; e_sb_v = m_bvalid; e_mb_rdy = s_bready;
            end
            MD: begin
                e_sw_rdy = m_wready; e_mw_v = s_wvalid;
                e_sb_v = m_bvalid && outs > 0; e_mb_rdy = s_bready && outs > 0;
            end
            MFA: e_saw_rdy = 1;
            MFW: e_sw_rdy = 1;
            MFB: begin e_sb_v = 1; e_bid = fid; e_bresp = 2'b10; end
            default: ;
        endcase
        if (mvalid) begin
            cmp("s_awready", s_awready, e_saw_rdy);
            cmp("m_awvalid", m_awvalid, e_maw_v);
            cmp("s_wready", s_wready, e_sw_rdy);
            cmp("m_wvalid", m_wvalid, e_mw_v);
            cmp("s_bvalid", s_bvalid, e_sb_v);
            cmp("m_bready", m_bready, e_mb_rdy);
            cmp("fence_active", fence_active, ph != MP);
            cmp("cfg_ack", cfg_ack, e_ack);
            cmp("cfg_rdata", cfg_rdata, e_rdata);
            if (e_maw_v) begin
                cmp("m_aw_fields", {m_awid, m_awaddr, m_awlen, m_awsize},
                    {s_awid, s_awaddr, s_awlen, s_awsize});
            end
            if (e_mw_v) begin
                cmp("m_wdata", m_wdata, s_wdata);
                cmp("m_wstrb_last", {m_wstrb, m_wlast}, {s_wstrb, s_wlast});
            end
            if (e_sb_v) cmp("s_b_fields", {s_bid, s_bresp}, {e_bid, e_bresp});
        end
        // advance to the state after the coming rising edge
        if (!rst_n) begin
            ph = MP; outs = 0; cnt = 0; fid = 0; e_ack = 0; e_rdata = 0;
            wr_prev = 0; rd_prev = 0; mvalid = 1;
        end else if (mvalid) begin
            wr_r = cfg_wr && !wr_prev;
            rd_r = cfg_rd && !rd_prev;
            maw_hs = e_maw_v && m_awready;
            mb_hs = m_bvalid && e_mb_rdy && outs > 0;
            nph = ph;
            case (ph)
                MP:  if (wr_last_error) nph = MD;
                MD:  if (outs == 0) nph = MFA;
                MFA: begin
                    if (s_awvalid) begin nph = MFW; fid = s_awid; end
                    else if (wr_r && cfg_addr == 12'h0 && cfg_wdata[0] && !wr_last_error)
                        nph = MP;
                end
                MFW: if (s_wvalid && s_wlast) nph = MFB;
                MFB: if (s_bready) nph = MFA;
                default: ;
            endcase
            e_ack = wr_r || rd_r;
            if (rd_r) e_rdata = model_read(cfg_addr);
`ifdef AXI_WR_FENCE_CNT_EN
            if (wr_r && cfg_addr == 12'h8) cnt = 0;
            else if (ph == MFB && s_bready) cnt = cnt + 1;
`else
            cnt = 0;
`endif
            outs = outs + (maw_hs ? 1 : 0) - (mb_hs ? 1 : 0);
            ph = nph;
            wr_prev = cfg_wr; rd_prev = cfg_rd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit done = 0;
        s_awvalid = 1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd3;
        for (int n = 0; n < 50 && !done; n++) begin
            at_neg(); done = s_awready; step();
        end
        s_awvalid = 0;
        cmp("aw_handshake", done, 1);
    endtask

    task automatic send_w(input int beats, input logic [7:0] tag, input bit fwd);
        for (int b = 0; b < beats; b++) begin
            bit done = 0;
            s_wvalid = 1; s_wdata = {24'hA5A500, tag, 32'(b) * 32'h01010101};
            s_wstrb = 8'hF0 ^ 8'(b); s_wlast = (b == beats - 1);
            for (int n = 0; n < 50 && !done; n++) begin
                at_neg(); done = s_wready;
                if (done) cmp("w_forwarded", m_wvalid, fwd);
                step();
            end
            cmp("w_handshake", done, 1);
        end
        s_wvalid = 0; s_wlast = 0;
    endtask

    task automatic slave_b(input logic [7:0] id, input logic [1:0] resp);
        bit done = 0;
        m_bvalid = 1; m_bid = id; m_bresp = resp;
        for (int n = 0; n < 50 && !done; n++) begin
            at_neg(); done = m_bready;
            if (done) cmp("b_passthru", {s_bvalid, s_bid, s_bresp}, {1'b1, id, resp});
            step();
        end
        m_bvalid = 0;
        cmp("b_handshake", done, 1);
    endtask

    task automatic fence_b(output logic [7:0] id, output logic [1:0] resp);
        bit done = 0;
        id = 0; resp = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            at_neg(); done = s_bvalid && s_bready;
            if (done) begin id = s_bid; resp = s_bresp; end
            step();
        end
        cmp("fence_b_seen", done, 1);
    endtask

    task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_wr = 1; step(); cfg_wr = 0; step();
    endtask

    task automatic cfg_read(input logic [11:0] a, output logic [31:0] d);
        cfg_addr = a; cfg_rd = 1; step(); cfg_rd = 0;
        at_neg(); d = cfg_rdata; cmp("cfg_read_ack", cfg_ack, 1); step();
    endtask

    logic [31:0] rd;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic [31:0] exp_cnt1, exp_cnt2;

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
`ifdef AXI_WR_FENCE_CNT_EN
        exp_cnt1 = 1; exp_cnt2 = 2;
`else
        exp_cnt1 = 0; exp_cnt2 = 0;
`endif
        rst_n = 0; cfg_addr = 0; cfg_wr = 0; cfg_rd = 0; cfg_wdata = 0; wr_last_error = 0;
        s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awvalid = 0;
        s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0; s_bready = 1;
        m_awready = 1; m_wready = 1; m_bid = 0; m_bresp = 0; m_bvalid = 0;
        repeat (3) step();
        rst_n = 1;
        at_neg();
        cmp("rst_fence_active", fence_active, 0);
        cmp("rst_cfg", {cfg_ack, cfg_rdata}, 33'h0);
        cmp("rst_valids", {s_bvalid, m_awvalid, m_wvalid}, 3'b000);
        step();
        cfg_read(12'h0, rd); cmp("rst_ctrl", rd, 32'h0);

        // Pass-through: three 4-beat bursts
        for (int i = 0; i < 3; i++) begin
            send_aw(8'(i + 1), 32'h1000 + 32'(i) * 32'h40, 8'd3);
            send_w(4, 8'(i), 1);
            slave_b(8'(i + 1), (i == 1) ? 2'b01 : 2'b00);
        end
        cfg_read(12'h4, rd); cmp("pass_outs_zero", rd, 32'h0);

        // Two outstanding, then error: drain before fencing
        send_aw(8'h21, 32'h2000, 8'd0); send_w(1, 8'h21, 1);
        send_aw(8'h22, 32'h2040, 8'd0); send_w(1, 8'h22, 1);
        wr_last_error = 1; step();
        s_awvalid = 1; s_awid = 8'h77;
        for (int n = 0; n < 3; n++) begin
            at_neg(); cmp("drain_awready", s_awready, 0); step();
        end
        s_awvalid = 0;
        slave_b(8'h21, 2'b00);
        at_neg(); cmp("drain_active", fence_active, 1); step();
        slave_b(8'h22, 2'b00);
        step();
        cfg_read(12'h4, rd); cmp("drain_outs_zero", rd, 32'h0);
        cfg_read(12'h0, rd); cmp("faw_ctrl", rd, 32'h3);

        // Locally terminated write
        send_aw(8'h5A, 32'h3000, 8'd1);
        send_w(2, 8'h5A, 0);
        fence_b(bid, bresp);
        cmp("fence_bid", bid, 8'h5A);
        cmp("fence_bresp", bresp, 2'b10);
        cfg_read(12'h8, rd); cmp("fence_cnt_1", rd, exp_cnt1);

        // Re-arm ignored while error still asserted
        cfg_write(12'h0, 32'h1);
        cfg_read(12'h0, rd); cmp("rearm_err_ignored", rd, 32'h3);

        // Re-arm ignored mid-burst
        send_aw(8'h33, 32'h3100, 8'd0);
        wr_last_error = 0;
        cfg_write(12'h0, 32'h1);
        cfg_read(12'h0, rd); cmp("rearm_fw_ignored", rd, 32'h6);
        send_w(1, 8'h33, 0);
        fence_b(bid, bresp);
        cmp("fence_bid2", {bid, bresp}, {8'h33, 2'b10});
        cfg_read(12'h8, rd); cmp("fence_cnt_2", rd, exp_cnt2);
        cfg_write(12'h8, 32'hDEAD);
        cfg_read(12'h8, rd); cmp("fence_cnt_clr", rd, 32'h0);

        // Valid re-arm
        cfg_write(12'h0, 32'h1);
        at_neg(); cmp("rearm_pass", fence_active, 0); step();
        cfg_read(12'h0, rd); cmp("rearm_ctrl", rd, 32'h0);

        // Outstanding limit with slave withholding B
        send_aw(8'h10, 32'h4000, 8'd0);
        send_aw(8'h11, 32'h4040, 8'd0);
        s_awvalid = 1; s_awid = 8'h12; s_awaddr = 32'h4080; s_awlen = 0;
        for (int n = 0; n < 3; n++) begin
            at_neg(); cmp("max_stall", {s_awready, m_awvalid}, 2'b00); step();
        end
        m_bvalid = 1; m_bid = 8'h10; m_bresp = 2'b00;
        at_neg(); cmp("max_stall_b", {s_awready, m_bready}, 2'b01); step();
        m_bid = 8'h11;
        at_neg(); cmp("simul_aw_b", {s_awready, m_bready}, 2'b11); step();
        m_bvalid = 0; s_awid = 8'h13; s_awaddr = 32'h40C0;
        at_neg(); cmp("refill_aw", s_awready, 1); step();
        s_awvalid = 0;
        cfg_read(12'h4, rd); cmp("outs_two", rd, 32'h2);
        slave_b(8'h12, 2'b00);
        slave_b(8'h13, 2'b11);
        cfg_read(12'h4, rd); cmp("outs_back_zero", rd, 32'h0);

        // Reset while holding a fenced B
        wr_last_error = 1; step(); step();
        send_aw(8'h44, 32'h5000, 8'd0);
        s_bready = 0;
        send_w(1, 8'h44, 0);
        at_neg(); cmp("fb_held", {s_bvalid, s_bid, s_bresp}, {1'b1, 8'h44, 2'b10}); step();
        rst_n = 0; wr_last_error = 0; step();
        rst_n = 1;
        at_neg(); cmp("rst_fb", {s_bvalid, fence_active}, 2'b00); step();
        s_bready = 1;
        cfg_read(12'h4, rd); cmp("rst_outs", rd, 32'h0);
        cfg_read(12'h0, rd); cmp("rst_ctrl2", rd, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
